alu_seq: RTL
============

Name: alu_seq

Overview:
Next-generation ALU. It is parametrised in data width and registers its result with a valid/ready input handshake and a one-cycle output valid strobe. It adds variable-amount shifts and rotates, status flags, and iterative multi-cycle multiply and unsigned divide. It sits between the register file read ports and the write-back path, replacing the purely combinational ALU.

Parameters:
SIZE, 8, data width in bits; power of two, minimum 4
SHW, $clog2(SIZE), width of the shift-amount field taken from i_reg1; derived, not overridden

Ports:
i_clk  in  1  clock; all state changes on the rising edge
i_rst  in  1  synchronous reset, active-high
i_valid  in  1  operation request
o_ready  out  1  block can accept a request this cycle
i_do  in  4  opcode, sampled on accept
i_reg0  in  SIZE  operand A, sampled on accept
i_reg1  in  SIZE  operand B, sampled on accept
o_valid  out  1  o_out/o_flags hold a new result (one-cycle pulse)
o_out  out  SIZE  result
o_flags  out  4  {Z,N,C,V}

Behaviour:
- Accept: an operation is accepted on a rising edge where i_valid && o_ready. Requests arriving while o_ready=0 are ignored, not queued.
- Opcodes (A=i_reg0, B=i_reg1, amt=B[SHW-1:0]):
  - 0 MOV: A.
  - 1 LSL: A<<amt. 2 LSR: A>>amt, logical. 3 ASR: A>>>amt, signed. 4 ROL: rotate A left by amt.
  - 5 ADD: A+B. 6 SUB: A-B.
  - 7 OR. 8 AND. 9 XOR.
  - 10 CND: signed compare; result 0=EQ, 1=A>B, 2=A<B, zero-extended to SIZE.
  - 11 MUL: low SIZE bits of unsigned A*B. 12 MULH: high SIZE bits.
  - 13 DIV: unsigned A/B. 14 MOD: unsigned A%B.
  - 15 NOT: ~A.
- Flags:
  - Z: result==0. N: result[SIZE-1].
  - C, ADD: carry out. C, SUB and CND: unsigned borrow (A<B).
  - C, LSL/LSR/ASR: last bit shifted out; 0 when amt=0. C, ROL: result[0].
  - C, MUL/MULH: high half of the product nonzero.
  - C, all other ops: 0.
  - V, ADD/SUB: signed overflow. V, DIV/MOD: divide by zero. V, all other ops: 0.
- Single-cycle ops (0-10, 15): the result is registered on the accepting edge. o_valid is high for the one following cycle. o_ready stays 1.
- Multi-cycle ops (11-14) use FSM IDLE -> MUL or DIV -> IDLE:
  - MUL: shift-add, one bit per cycle. DIV: restoring division, one quotient bit per cycle.
  - Iteration counter runs 0..SIZE-1. Exactly SIZE iteration edges follow the accepting edge.
  - o_out, o_flags and o_valid update on the last iteration edge. o_valid is therefore high SIZE+1 edges after accept.
  - o_ready=0 from the accepting edge until that last iteration edge. In the o_valid cycle the FSM is back in IDLE with o_ready=1, so a new op can be accepted in the same cycle (back-to-back, no bubble).
- Divide by zero still takes the full SIZE cycles. DIV returns all-ones; MOD returns A; V=1.
- Outputs:
  - o_ready is combinational from state: 1 in IDLE, else 0.
  - o_out and o_flags hold their last value until the next result.
  - o_valid is a pulse only; there is no output backpressure.
- Reset, synchronous, on any edge with i_rst=1:
  - state=IDLE, counter=0, o_valid=0, o_out=0, o_flags=0.
  - o_ready reads 1 after that edge.
  - i_valid is ignored on a reset edge.
  - Reset mid MUL/DIV aborts the op; no o_valid is produced for it.
- Widths: all arithmetic is done in SIZE+1 bits for carry. The product is 2*SIZE internally. Only amt bits are used for shifts; B[SIZE-1:SHW] are ignored.

Test Plan:
- SIZE=8. ADD 0x7F+0x01 -> o_out=0x80, flags Z0 N1 C0 V1. SUB 0x00-0x01 -> 0xFF, N1 C1 V0. ADD 0xFF+0x01 -> 0x00, Z1 C1. o_valid exactly 1 cycle after accept; o_ready never drops.
- CND:
  - 5,5 -> 0x00, Z1.
  - 3,5 -> 0x02.
  - 0x80,0x01 -> 0x02 (signed less), C0.
  - 0x01,0x80 -> 0x01.
- Shifts:
  - LSL 0x81 amt1 -> 0x02, C1.
  - ASR 0x80 amt3 -> 0xF0, C0.
  - ROL 0x81 amt4 -> 0x18.
  - LSL 0x81 with B=0x09 -> 0x02 (only B[2:0] used).
  - LSR 0x55 amt0 -> 0x55, C0.
- Multiply:
  - MUL 0x10*0x10 -> 0x00, Z1 C1. o_valid exactly 9 edges after accept; o_ready low for 8 cycles.
  - MULH same operands -> 0x01.
  - ADD issued in the o_valid cycle is accepted; its result appears on the next cycle.
- Divide:
  - DIV 200/7 -> 0x1C. MOD 200/7 -> 0x04, V0.
  - DIV 0x55/0 -> 0xFF, V1. MOD 0x55/0 -> 0x55, V1.
  - i_valid pulsed while o_ready=0 -> ignored, no extra o_valid.
- Reset:
  - Assert i_rst 4 cycles into a DIV -> no o_valid; o_out=0, o_flags=0, o_ready=1 on the next cycle.
  - A following ADD 2+3 -> 0x05 with normal 1-cycle latency.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/shift/add ops plus iterative shift-add multiply
// and restoring unsigned divide, with a valid/ready input handshake and a result strobe.
module alu_seq #(
    parameter int SIZE = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [3:0]      i_do,
    input  logic [SIZE-1:0] i_reg0,
    input  logic [SIZE-1:0] i_reg1,
    output logic            o_valid,
    output logic [SIZE-1:0] o_out,
    output logic [3:0]      o_flags
);
    localparam int SHW = $clog2(SIZE);
    localparam int MSB = SIZE - 1;
    localparam logic [SHW:0]   SZ   = (SHW+1)'(SIZE);
    localparam logic [SHW-1:0] LAST = SHW'(SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t          state_q;
    logic [SHW-1:0]  cnt_q;
    logic            sel_hi_q;   // MULH / MOD pick the upper half of {hi,lo}
    logic [SIZE-1:0] opnd_q, hi_q, lo_q;

    logic            accept;
    logic [SHW-1:0]  amt;
    logic [SIZE:0]   add_w, sub_w, lsl_w, lsr_w, asr_w;
    logic [SIZE-1:0] rol_w;
    logic [SIZE-1:0] alu_res;
    logic            alu_c, alu_v;

    assign o_ready = (state_q == S_IDLE);
    assign accept  = i_valid && o_ready;
    assign amt     = i_reg1[SHW-1:0];

    assign add_w = {1'b0, i_reg0} + {1'b0, i_reg1};
    assign sub_w = {1'b0, i_reg0} - {1'b0, i_reg1};
    // Shifts carry one extra bit so the last bit shifted out lands in a fixed position.
    assign lsl_w = {1'b0, i_reg0} << amt;
    assign lsr_w = {i_reg0, 1'b0} >> amt;
    assign asr_w = $signed({i_reg0, 1'b0}) >>> amt;
    assign rol_w = (i_reg0 << amt) | (i_reg0 >> (SZ - {1'b0, amt}));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (i_do)
            4'd0:  alu_res = i_reg0;
            4'd1:  begin alu_res = lsl_w[SIZE-1:0]; alu_c = lsl_w[SIZE]; end
            4'd2:  begin alu_res = lsr_w[SIZE:1];   alu_c = lsr_w[0];    end
            4'd3:  begin alu_res = asr_w[SIZE:1];   alu_c = asr_w[0];    end
            4'd4:  begin alu_res = rol_w;           alu_c = rol_w[0];    end
            4'd5: begin
                alu_res = add_w[SIZE-1:0];
                alu_c   = add_w[SIZE];
                alu_v   = (i_reg0[MSB] == i_reg1[MSB]) && (add_w[MSB] != i_reg0[MSB]);
            end
            4'd6: begin
                alu_res = sub_w[SIZE-1:0];
                alu_c   = sub_w[SIZE];
                alu_v   = (i_reg0[MSB] != i_reg1[MSB]) && (sub_w[MSB] != i_reg0[MSB]);
            end
            4'd7:  alu_res = i_reg0 | i_reg1;
            4'd8:  alu_res = i_reg0 & i_reg1;
            4'd9:  alu_res = i_reg0 ^ i_reg1;
            4'd10: begin
                if (i_reg0 == i_reg1)                        alu_res = '0;
                else if ($signed(i_reg0) > $signed(i_reg1)) alu_res = SIZE'(1);
                else                                         alu_res = SIZE'(2);
                alu_c = sub_w[SIZE];
            end
            4'd15: alu_res = ~i_reg0;
            default: alu_res = '0;
        endcase
    end

    // One iteration of each multi-cycle engine; {hi,lo} is shared between them.
    logic [SIZE:0]   mul_sum, div_trial, div_diff;
    logic [SIZE-1:0] mul_hi_d, mul_lo_d, div_hi_d, div_lo_d;
    logic [SIZE-1:0] fin_res;
    logic            fin_c, fin_v;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_d  = mul_sum[SIZE:1];
    assign mul_lo_d  = {mul_sum[0], lo_q[SIZE-1:1]};
    assign div_trial = {hi_q, lo_q[SIZE-1]};
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_hi_d  = div_diff[SIZE] ? div_trial[SIZE-1:0] : div_diff[SIZE-1:0];
    assign div_lo_d  = {lo_q[SIZE-2:0], ~div_diff[SIZE]};

    always_comb begin
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        if (state_q == S_MUL) begin
            fin_res = sel_hi_q ? mul_hi_d : mul_lo_d;
            fin_c   = |mul_hi_d;
        end else if (state_q == S_DIV) begin
            fin_res = sel_hi_q ? div_hi_d : div_lo_d;
            fin_v   = (opnd_q == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_hi_q <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            o_valid  <= 1'b0;
            o_out    <= '0;
            o_flags  <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    if (i_do inside {4'd11, 4'd12}) begin
                        state_q  <= S_MUL;
                        cnt_q    <= '0;
                        sel_hi_q <= (i_do == 4'd12);
                        opnd_q   <= i_reg0;
                        hi_q     <= '0;
                        lo_q     <= i_reg1;
                    end else if (i_do inside {4'd13, 4'd14}) begin
                        state_q  <= S_DIV;
                        cnt_q    <= '0;
                        sel_hi_q <= (i_do == 4'd14);
                        opnd_q   <= i_reg1;
                        hi_q     <= '0;
                        lo_q     <= i_reg0;
                    end else begin
                        o_valid <= 1'b1;
                        o_out   <= alu_res;
                        o_flags <= {alu_res == '0, alu_res[MSB], alu_c, alu_v};
                    end
                end
                S_MUL, S_DIV: begin
                    hi_q  <= (state_q == S_MUL) ? mul_hi_d : div_hi_d;
                    lo_q  <= (state_q == S_MUL) ? mul_lo_d : div_lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        o_valid <= 1'b1;
                        o_out   <= fin_res;
                        o_flags <= {fin_res == '0, fin_res[MSB], fin_c, fin_v};
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
